// File: rtl/uproc_pkg.sv
// Shared types and helpers for the uProcessor register file.
package uproc_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int NUM_REGS_DEF = 4;

   typedef logic [DATA_W_DEF-1:0] word_t;

   // An address is valid only below NUM_REGS; non-power-of-2 files have holes.
   function automatic logic is_valid_addr(input int unsigned addr, input int unsigned num_regs);
      return (addr < num_regs);
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy tracking and hazard stall for the issue stage.
module reg_scoreboard
   import uproc_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = $clog2(NUM_REGS_DEF),
   parameter bit ZERO_REG = 1'b0
) (
   input  logic                clk,
   input  logic                nReset,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [ADDR_W-1:0]   rd_a_addr,
   input  logic                rd_a_use,
   input  logic [ADDR_W-1:0]   rd_b_addr,
   input  logic                rd_b_use,
   input  logic                issue_en,
   input  logic [ADDR_W-1:0]   issue_addr,
   output logic                stall,
   output logic [NUM_REGS-1:0] busy_vec
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [NUM_REGS-1:0] beff;
   logic [NUM_REGS-1:0] clr_vec;
   logic [NUM_REGS-1:0] set_vec;
   logic                a_busy;
   logic                b_busy;
   logic                d_busy;
   logic                issue_ok;

   // A same-cycle writeback frees the register; a same-cycle accepted issue re-arms it.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      localparam bit IS_ZERO = ZERO_REG && (gi == 0);
      assign clr_vec[gi] = wr_en && (wr_addr == ADDR_W'(gi));
      assign beff[gi]    = busy_q[gi] & ~clr_vec[gi];
      assign set_vec[gi] = issue_ok && (issue_addr == ADDR_W'(gi)) && !IS_ZERO;
      assign busy_d[gi]  = IS_ZERO ? 1'b0 : (set_vec[gi] | beff[gi]);
   end

   always_comb begin
      a_busy = 1'b0;
      b_busy = 1'b0;
      d_busy = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_a_addr == ADDR_W'(i))  a_busy = beff[i];
         if (rd_b_addr == ADDR_W'(i))  b_busy = beff[i];
         if (issue_addr == ADDR_W'(i)) d_busy = beff[i];
      end
      stall = nReset & issue_en & ((rd_a_use & a_busy) | (rd_b_use & b_busy) | d_busy);
   end

   assign issue_ok = nReset & issue_en & ~stall & is_valid_addr(32'(issue_addr), NUM_REGS);

   always_ff @(posedge clk) begin
      if (!nReset) busy_q <= '0;
      else         busy_q <= busy_d;
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_scb.sv
// Binary-addressed register file: one write port, two combinational read
// ports with write-through bypass, plus the busy scoreboard.
module reg_file_scb
   import uproc_pkg::*;
#(
   parameter int   DATA_W   = DATA_W_DEF,
   parameter int   NUM_REGS = NUM_REGS_DEF,
   parameter bit   ZERO_REG = 1'b0,
   localparam int  ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                nReset,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [ADDR_W-1:0]   rd_a_addr,
   input  logic                rd_a_use,
   output logic [DATA_W-1:0]   rd_a_data,
   input  logic [ADDR_W-1:0]   rd_b_addr,
   input  logic                rd_b_use,
   output logic [DATA_W-1:0]   rd_b_data,
   input  logic                issue_en,
   input  logic [ADDR_W-1:0]   issue_addr,
   output logic                stall,
   output logic [NUM_REGS-1:0] busy_vec
);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] wr_hit;

   // wr_hit also drives the bypass, so a write ignored by reset or r0 is never forwarded.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_dec
      localparam bit IS_ZERO = ZERO_REG && (gi == 0);
      assign wr_hit[gi] = nReset && wr_en && (wr_addr == ADDR_W'(gi)) && !IS_ZERO;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REGS; i++) begin
         if (!nReset)        regs_q[i] <= '0;
         else if (wr_hit[i]) regs_q[i] <= wr_data;
      end
   end

   always_comb begin
      rd_a_data = '0;
      rd_b_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_a_addr == ADDR_W'(i)) rd_a_data = wr_hit[i] ? wr_data : regs_q[i];
         if (rd_b_addr == ADDR_W'(i)) rd_b_data = wr_hit[i] ? wr_data : regs_q[i];
      end
   end

   reg_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scb (
      .clk        (clk),
      .nReset     (nReset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .rd_a_addr  (rd_a_addr),
      .rd_a_use   (rd_a_use),
      .rd_b_addr  (rd_b_addr),
      .rd_b_use   (rd_b_use),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .stall      (stall),
      .busy_vec   (busy_vec)
   );

endmodule

// File: tb/tb_reg_file_scb.sv
// Self-checking bench: vector table on a 4x8 file, hand sequence on a 6x8 file with r0 hardwired.
module tb_reg_file_scb;
   import uproc_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 4-register file, ZERO_REG=0
   logic       n, we, au, bu, ie, st;
   logic [1:0] wa, ra, rb, ia;
   word_t      wd, rda, rdb;
   logic [3:0] busy;

   reg_file_scb #(.DATA_W(8), .NUM_REGS(4), .ZERO_REG(1'b0)) u0 (
      .clk(clk), .nReset(n), .wr_en(we), .wr_addr(wa), .wr_data(wd),
      .rd_a_addr(ra), .rd_a_use(au), .rd_a_data(rda),
      .rd_b_addr(rb), .rd_b_use(bu), .rd_b_data(rdb),
      .issue_en(ie), .issue_addr(ia), .stall(st), .busy_vec(busy)
   );

   // 6-register file, ZERO_REG=1
   logic       zn, zwe, zau, zbu, zie, zst;
   logic [2:0] zwa, zra, zrb, zia;
   word_t      zwd, zrda, zrdb;
   logic [5:0] zbusy;

   reg_file_scb #(.DATA_W(8), .NUM_REGS(6), .ZERO_REG(1'b1)) u1 (
      .clk(clk), .nReset(zn), .wr_en(zwe), .wr_addr(zwa), .wr_data(zwd),
      .rd_a_addr(zra), .rd_a_use(zau), .rd_a_data(zrda),
      .rd_b_addr(zrb), .rd_b_use(zbu), .rd_b_data(zrdb),
      .issue_en(zie), .issue_addr(zia), .stall(zst), .busy_vec(zbusy)
   );

   typedef struct {
      logic       n, we;
      logic [1:0] wa;
      logic [7:0] wd;
      logic [1:0] ra;
      logic       au;
      logic [1:0] rb;
      logic       bu, ie;
      logic [1:0] ia;
      logic [7:0] e_ra, e_rb;
      logic       e_st;
      logic [3:0] e_busy;
   } vec_t;

   int checks   = 0;
   int failures = 0;
   vec_t vecs [23];
   logic [3:0] exp_busy_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic vn, input logic vwe, input logic [1:0] vwa, input logic [7:0] vwd,
                               input logic [1:0] vra, input logic vau, input logic [1:0] vrb, input logic vbu,
                               input logic vie, input logic [1:0] via,
                               input logic [7:0] era, input logic [7:0] erb, input logic est, input logic [3:0] eb);
      vec_t v;
      v.n = vn; v.we = vwe; v.wa = vwa; v.wd = vwd; v.ra = vra; v.au = vau; v.rb = vrb; v.bu = vbu;
      v.ie = vie; v.ia = via; v.e_ra = era; v.e_rb = erb; v.e_st = est; v.e_busy = eb;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] eb;
      n = 1'b0; we = 1'b1; wa = 2'd2; wd = 8'hAA; ra = 2'd2; au = 1'b0; rb = 2'd0; bu = 1'b0; ie = 1'b1; ia = 2'd1;
      zn = 1'b0; zwe = 1'b0; zwa = '0; zwd = '0; zra = '0; zau = 1'b0; zrb = '0; zbu = 1'b0; zie = 1'b0; zia = '0;

      //          n  we wa  wd     ra au rb bu ie ia   e_ra   e_rb   st e_busy
      vecs[0]  = mk(1, 0, 0, 8'h00, 2, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 4'b0000);
      vecs[1]  = mk(1, 1, 1, 8'h5A, 1, 0, 0, 0, 0, 0, 8'h5A, 8'h00, 0, 4'b0000);
      vecs[2]  = mk(1, 0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h5A, 8'h5A, 0, 4'b0000);
      vecs[3]  = mk(1, 1, 1, 8'h3C, 1, 0, 0, 0, 0, 0, 8'h3C, 8'h00, 0, 4'b0000);
      vecs[4]  = mk(1, 0, 0, 8'h00, 1, 0, 2, 0, 0, 0, 8'h3C, 8'h00, 0, 4'b0000);
      vecs[5]  = mk(1, 0, 0, 8'h00, 1, 0, 0, 0, 1, 2, 8'h3C, 8'h00, 0, 4'b0100);
      vecs[6]  = mk(1, 0, 0, 8'h00, 2, 1, 1, 0, 1, 3, 8'h00, 8'h3C, 1, 4'b0100);
      vecs[7]  = mk(1, 1, 2, 8'h11, 2, 1, 1, 0, 1, 3, 8'h11, 8'h3C, 0, 4'b1000);
      vecs[8]  = mk(1, 0, 0, 8'h00, 2, 0, 3, 0, 1, 3, 8'h11, 8'h00, 1, 4'b1000);
      vecs[9]  = mk(1, 0, 0, 8'h00, 2, 0, 3, 1, 1, 0, 8'h11, 8'h00, 1, 4'b1000);
      vecs[10] = mk(1, 0, 0, 8'h00, 1, 0, 3, 0, 1, 1, 8'h3C, 8'h00, 0, 4'b1010);
      vecs[11] = mk(1, 1, 1, 8'h22, 1, 0, 0, 0, 1, 1, 8'h22, 8'h00, 0, 4'b1010);
      vecs[12] = mk(1, 0, 0, 8'h00, 1, 0, 2, 0, 0, 0, 8'h22, 8'h11, 0, 4'b1010);
      vecs[13] = mk(1, 1, 3, 8'h77, 3, 0, 1, 0, 0, 0, 8'h77, 8'h22, 0, 4'b0010);
      vecs[14] = mk(1, 0, 0, 8'h00, 3, 0, 1, 0, 1, 2, 8'h77, 8'h22, 0, 4'b0110);
      vecs[15] = mk(0, 1, 0, 8'h99, 3, 0, 2, 0, 1, 0, 8'h77, 8'h11, 0, 4'b0000);
      vecs[16] = mk(1, 0, 0, 8'h00, 1, 0, 2, 0, 0, 0, 8'h00, 8'h00, 0, 4'b0000);
      vecs[17] = mk(1, 0, 0, 8'h00, 3, 0, 0, 0, 1, 3, 8'h00, 8'h00, 0, 4'b1000);
      vecs[18] = mk(1, 1, 0, 8'h0F, 0, 0, 3, 0, 0, 0, 8'h0F, 8'h00, 0, 4'b1000);
      vecs[19] = mk(1, 1, 2, 8'hA5, 2, 1, 3, 0, 1, 1, 8'hA5, 8'h00, 0, 4'b1010);
      vecs[20] = mk(1, 0, 0, 8'h00, 2, 0, 0, 0, 0, 0, 8'hA5, 8'h0F, 0, 4'b1010);
      vecs[21] = mk(1, 1, 0, 8'h44, 0, 0, 2, 0, 1, 3, 8'h44, 8'hA5, 1, 4'b1010);
      vecs[22] = mk(1, 0, 0, 8'h00, 0, 0, 2, 0, 0, 0, 8'h44, 8'hA5, 0, 4'b1010);

      // Reset held two edges with a write and an issue pending: both must be ignored.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); #1;
         chk("rst_stall", 32'(st), 32'd0);
         @(posedge clk);
      end
      #1;
      chk("rst_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         n = vecs[i].n; we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
         ra = vecs[i].ra; au = vecs[i].au; rb = vecs[i].rb; bu = vecs[i].bu;
         ie = vecs[i].ie; ia = vecs[i].ia;
         #1;
         chk($sformatf("v%0d_rd_a", i), 32'(rda), 32'(vecs[i].e_ra));
         chk($sformatf("v%0d_rd_b", i), 32'(rdb), 32'(vecs[i].e_rb));
         chk($sformatf("v%0d_stall", i), 32'(st), 32'(vecs[i].e_st));
         exp_busy_q.push_back(vecs[i].e_busy);
         @(posedge clk); #1;
         if (exp_busy_q.size() == 0) begin
            chk($sformatf("v%0d_sb_empty", i), 32'd0, 32'd1);
         end else begin
            eb = exp_busy_q.pop_front();
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(eb));
         end
         $display("vec %0d n=%0b we=%0b wa=%0d wd=%02h ra=%0d rb=%0d ie=%0b ia=%0d rda=%02h rdb=%02h stall=%0b busy=%04b",
                  i, n, we, wa, wd, ra, rb, ie, ia, rda, rdb, st, busy);
      end
      @(negedge clk);
      n = 1'b1; we = 1'b0; ie = 1'b0;

      // ZERO_REG=1, NUM_REGS=6 sequence
      @(posedge clk); #1;
      zn = 1'b1;
      @(negedge clk);
      zwe = 1'b1; zwa = 3'd0; zwd = 8'hFF; zra = 3'd0;
      #1; chk("z_r0_bypass", 32'(zrda), 32'd0);
      @(negedge clk);
      zwe = 1'b0;
      #1; chk("z_r0_read", 32'(zrda), 32'd0);
      $display("z write r0=FF rd r0=%02h", zrda);

      zie = 1'b1; zia = 3'd0;
      #1; chk("z_iss_r0_stall", 32'(zst), 32'd0);
      @(posedge clk); #1;
      chk("z_iss_r0_busy", 32'(zbusy), 32'd0);
      $display("z issue r0 stall=%0b busy=%06b", zst, zbusy);

      @(negedge clk);
      zia = 3'd5; zra = 3'd7; zau = 1'b1;
      #1;
      chk("z_rd7", 32'(zrda), 32'd0);
      chk("z_iss5_stall", 32'(zst), 32'd0);
      @(posedge clk); #1;
      chk("z_iss5_busy", 32'(zbusy), 32'b100000);
      $display("z issue r5 rd7=%02h busy=%06b", zrda, zbusy);

      @(negedge clk);
      zia = 3'd6; zwe = 1'b1; zwa = 3'd7; zwd = 8'h03; zau = 1'b0;
      #1; chk("z_iss6_stall", 32'(zst), 32'd0);
      @(posedge clk); #1;
      chk("z_iss6_busy", 32'(zbusy), 32'b100000);
      $display("z issue r6 wr r7 busy=%06b", zbusy);

      @(negedge clk);
      zie = 1'b0; zwa = 3'd5; zwd = 8'h5B; zra = 3'd5; zrb = 3'd7;
      #1;
      chk("z_r5_bypass", 32'(zrda), 32'h5B);
      chk("z_rd7_b", 32'(zrdb), 32'd0);
      @(posedge clk); #1;
      chk("z_r5_release", 32'(zbusy), 32'd0);
      $display("z write r5=5B rd=%02h busy=%06b", zrda, zbusy);

      @(negedge clk);
      zwe = 1'b0; zie = 1'b1; zia = 3'd0; zau = 1'b1; zra = 3'd0;
      #1; chk("z_iss_r0_raw", 32'(zst), 32'd0);
      @(posedge clk); #1;
      chk("z_iss_r0_busy2", 32'(zbusy), 32'd0);
      $display("z issue r0 reading r0 stall=%0b busy=%06b", zst, zbusy);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
